// File: rtl/alu_logic_pkg.sv
// alu_logic_pkg
// Shared constants for the bitwise logic unit and anything that drives its
// op select (operand mux decode, later ALU stages reusing alu_logic_core).
//   OP_W      : width of the op select field
//   OP_*      : op select encodings
package alu_logic_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND   = 3'd0;
   localparam logic [OP_W-1:0] OP_OR    = 3'd1;
   localparam logic [OP_W-1:0] OP_NOR   = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XNOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_NAND  = 3'd5;
   localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASSA = 3'd7;

endpackage

// File: rtl/alu_logic_core.sv
// alu_logic_core
// Purely combinational WIDTH-bit bitwise logic op with result flags.
// Ports:
//   a, b    in  WIDTH  operands (b ignored by NOTA / PASSA)
//   op      in  OP_W   op select, encodings in alu_logic_pkg
//   y       out WIDTH  result
//   zero    out 1      y == 0
//   ones    out 1      y is all ones
//   parity  out 1      XOR-reduce of y
module alu_logic_core
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             ones,
   output logic             parity
);

   always_comb begin
      y = a;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         OP_NOTA: y = ~a;
         default: y = a;
      endcase
   end

   assign zero   = ~|y;
   assign ones   = &y;
   assign parity = ^y;

endmodule

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe
// Two-stage elastic pipeline around alu_logic_core. Stage 1 captures the
// operand beat, stage 2 holds the result and its flags. valid/ready on both
// sides; a full pipe can retire and accept in the same cycle.
// Ports:
//   clk, rst     clock (rising edge), async active-high reset
//   in_valid     in   operand beat valid
//   in_ready     out  pipe can accept an operand beat (independent of in_valid)
//   in_a, in_b   in   operands, WIDTH bits
//   in_op        in   op select
//   out_valid    out  result beat valid
//   out_ready    in   downstream accepts result
//   out_y        out  result, WIDTH bits
//   out_zero     out  out_y == 0
//   out_ones     out  out_y all ones
//   out_parity   out  XOR-reduce of out_y
//   op_count     out  saturating count of results taken downstream
module alu_logic_pipe
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [OP_W-1:0]  in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_ones,
   output logic             out_parity,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [OP_W-1:0]  s1_op;
   logic             s2_valid;
   logic             s1_ready;
   logic             s2_ready;
   logic             in_fire;
   logic             out_fire;

   logic [WIDTH-1:0] core_y;
   logic             core_zero;
   logic             core_ones;
   logic             core_parity;

   // A stage is free if empty or if its contents move on this cycle.
   assign s2_ready  = !s2_valid || out_ready;
   assign s1_ready  = !s1_valid || s2_ready;
   assign in_ready  = s1_ready;
   assign out_valid = s2_valid;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = s2_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
         end else if (s2_ready) begin
            s1_valid <= 1'b0;
         end
      end
   end

   alu_logic_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_op),
      .y      (core_y),
      .zero   (core_zero),
      .ones   (core_ones),
      .parity (core_parity)
   );

   // Result and flags load together so the flags always describe out_y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         out_y      <= '0;
         out_zero   <= 1'b0;
         out_ones   <= 1'b0;
         out_parity <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_y      <= core_y;
            out_zero   <= core_zero;
            out_ones   <= core_ones;
            out_parity <= core_parity;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (out_fire && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_logic_pipe.sv
module tb_alu_logic_pipe;
   import alu_logic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // shared stimulus for the WIDTH=4 instances (A: CNT_W=8, B: CNT_W=2)
   logic       iv, ordy;
   logic [3:0] ia, ib;
   logic [2:0] iop;
   logic       a_in_ready, a_out_valid, a_out_zero, a_out_ones, a_out_parity;
   logic [3:0] a_out_y;
   logic [7:0] a_op_count;
   logic       b_in_ready, b_out_valid, b_out_zero, b_out_ones, b_out_parity;
   logic [3:0] b_out_y;
   logic [1:0] b_op_count;

   // WIDTH=16 random instance
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [15:0] c_in_a, c_in_b, c_out_y;
   logic [2:0]  c_in_op;
   logic        c_out_zero, c_out_ones, c_out_parity;
   logic [7:0]  c_op_count;

   // WIDTH=1 instance
   logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [0:0] d_in_a, d_in_b, d_out_y;
   logic [2:0] d_in_op;
   logic       d_out_zero, d_out_ones, d_out_parity;
   logic [7:0] d_op_count;

   alu_logic_pipe #(.WIDTH(4), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(a_in_ready), .in_a(ia), .in_b(ib),
      .in_op(iop), .out_valid(a_out_valid), .out_ready(ordy), .out_y(a_out_y),
      .out_zero(a_out_zero), .out_ones(a_out_ones), .out_parity(a_out_parity),
      .op_count(a_op_count));

   alu_logic_pipe #(.WIDTH(4), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(b_in_ready), .in_a(ia), .in_b(ib),
      .in_op(iop), .out_valid(b_out_valid), .out_ready(ordy), .out_y(b_out_y),
      .out_zero(b_out_zero), .out_ones(b_out_ones), .out_parity(b_out_parity),
      .op_count(b_op_count));

   alu_logic_pipe #(.WIDTH(16), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_a(c_in_a),
      .in_b(c_in_b), .in_op(c_in_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_y(c_out_y), .out_zero(c_out_zero), .out_ones(c_out_ones),
      .out_parity(c_out_parity), .op_count(c_op_count));

   alu_logic_pipe #(.WIDTH(1), .CNT_W(8)) u_d (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a),
      .in_b(d_in_b), .in_op(d_in_op), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_y(d_out_y), .out_zero(d_out_zero), .out_ones(d_out_ones),
      .out_parity(d_out_parity), .op_count(d_op_count));

   typedef struct {
      logic [2:0] op;
      logic [3:0] a, b, y;
      logic       z, o, p;
   } vec_t;

   vec_t vecs[32];
   int   total = 0;
   int   bad = 0;
   int   cnt_a, cnt_b;

   function automatic logic [15:0] lmask(int w);
      return (w >= 16) ? 16'hFFFF : ((16'd1 << w) - 16'd1);
   endfunction

   function automatic logic [15:0] ref_y(logic [2:0] op, logic [15:0] a, logic [15:0] b, int w);
      logic [15:0] r;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = ~(a | b);
         3'd3: r = a ^ b;
         3'd4: r = ~(a ^ b);
         3'd5: r = ~(a & b);
         3'd6: r = ~a;
         default: r = a;
      endcase
      return r & lmask(w);
   endfunction

   function automatic logic [2:0] ref_flags(logic [15:0] y, int w);
      return {y == 16'd0, y == lmask(w), ^y};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      iv  = 1'b0;
      c_in_valid = 1'b0;
      d_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
   endtask

   // Streams vecs[0..n-1] back to back with out_ready=1 and checks each
   // result exactly two cycles after it was presented, plus both counters.
   task automatic stream(input int n);
      int acc, eb;
      ordy = 1'b1;
      for (int t = 0; t < n + 3; t++) begin
         @(negedge clk);
         acc = (t >= 3) ? t - 2 : 0;
         if (acc > n) acc = n;
         eb = cnt_b + acc;
         if (eb > 3) eb = 3;
         chk("cnt_a", a_op_count, cnt_a + acc);
         chk("cnt_b_sat", b_op_count, eb);
         chk("in_ready", a_in_ready, 1);
         if (t >= 2 && t < n + 2) begin
            chk("out_valid", a_out_valid, 1);
            chk("out_y", a_out_y, vecs[t-2].y);
            chk("flags", {a_out_zero, a_out_ones, a_out_parity},
                {vecs[t-2].z, vecs[t-2].o, vecs[t-2].p});
         end else if (t == n + 2) begin
            chk("out_valid_idle", a_out_valid, 0);
         end
         if (t < n) begin
            iv = 1'b1; ia = vecs[t].a; ib = vecs[t].b; iop = vecs[t].op;
         end else begin
            iv = 1'b0;
         end
      end
      cnt_a += n;
      cnt_b += n;
   endtask

   task automatic fill_nor(input logic [3:0] bval);
      logic [15:0] y;
      for (int i = 0; i < 16; i++) begin
         y = ref_y(3'd2, 16'(i), {12'd0, bval}, 4);
         vecs[i].op = 3'd2; vecs[i].a = 4'(i); vecs[i].b = bval; vecs[i].y = y[3:0];
         {vecs[i].z, vecs[i].o, vecs[i].p} = ref_flags(y, 4);
      end
   endtask

   task automatic drive_vec(input int i);
      iv = 1'b1; ia = vecs[i].a; ib = vecs[i].b; iop = vecs[i].op;
   endtask

   logic [18:0] sb[$];
   logic [18:0] held, exp_c;
   logic [15:0] yc;
   logic        stall;
   int          sent, got, cyc, k;
   logic [15:0] yd;

   initial begin
      rst = 1'b0; iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; iop = '0;
      c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_a = '0; c_in_b = '0; c_in_op = '0;
      d_in_valid = 1'b0; d_out_ready = 1'b1; d_in_a = '0; d_in_b = '0; d_in_op = '0;

      // reset values, observed while rst is held
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_out_y", a_out_y, 0);
      chk("rst_flags", {a_out_zero, a_out_ones, a_out_parity}, 0);
      chk("rst_op_count", a_op_count, 0);
      chk("rst_in_ready", a_in_ready, 1);
      do_reset();

      // exhaustive NOR sweeps
      fill_nor(4'b0000);
      stream(16);
      fill_nor(4'b1010);
      stream(16);

      // all eight ops on a=1100, b=1010
      do_reset();
      vecs[0] = '{OP_AND,   4'hC, 4'hA, 4'b1000, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{OP_OR,    4'hC, 4'hA, 4'b1110, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{OP_NOR,   4'hC, 4'hA, 4'b0001, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{OP_XOR,   4'hC, 4'hA, 4'b0110, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{OP_XNOR,  4'hC, 4'hA, 4'b1001, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{OP_NAND,  4'hC, 4'hA, 4'b0111, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{OP_NOTA,  4'hC, 4'hA, 4'b0011, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{OP_PASSA, 4'hC, 4'hA, 4'b1100, 1'b0, 1'b0, 1'b0};
      stream(8);
      chk("op_count_after_ops", a_op_count, 8);

      // NOR corner: a=0101, b=1010 -> all zero
      vecs[0] = '{OP_NOR, 4'b0101, 4'b1010, 4'b0000, 1'b1, 1'b0, 1'b0};
      stream(1);

      // backpressure: fill, stall, then release with full-pipe shift
      vecs[0] = '{OP_XOR,  4'h3, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{OP_AND,  4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{OP_OR,   4'hF, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{OP_NOTA, 4'h8, 4'h0, 4'h7, 1'b0, 1'b0, 1'b1};
      ordy = 1'b0;
      @(negedge clk); chk("bp_rdy0", a_in_ready, 1); drive_vec(0);
      @(negedge clk); chk("bp_rdy1", a_in_ready, 1); chk("bp_v1", a_out_valid, 0); drive_vec(1);
      @(negedge clk);
      chk("bp_full_rdy", a_in_ready, 0);
      chk("bp_v2", a_out_valid, 1);
      chk("bp_y0", a_out_y, vecs[0].y);
      drive_vec(2);
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_rdy", a_in_ready, 0);
         chk("bp_hold_valid", a_out_valid, 1);
         chk("bp_hold_y", a_out_y, vecs[0].y);
         chk("bp_hold_flags", {a_out_zero, a_out_ones, a_out_parity}, {vecs[0].z, vecs[0].o, vecs[0].p});
      end
      @(negedge clk);
      ordy = 1'b1;
      #1 chk("bp_shift_rdy", a_in_ready, 1);
      @(negedge clk); chk("bp_y1", a_out_y, vecs[1].y); chk("bp_f1", a_out_zero, 1); drive_vec(3);
      @(negedge clk); chk("bp_y2", a_out_y, vecs[2].y); chk("bp_f2", a_out_ones, 1); iv = 1'b0;
      @(negedge clk); chk("bp_y3", a_out_y, vecs[3].y); chk("bp_v3", a_out_valid, 1);
      @(negedge clk); chk("bp_empty", a_out_valid, 0);
      chk("bp_cnt_a", a_op_count, 13);
      chk("bp_cnt_b", b_op_count, 3);

      // saturation of the 2-bit counter over six results
      do_reset();
      fill_nor(4'b0110);
      stream(6);

      // async reset between clock edges with two beats in flight
      do_reset();
      ordy = 1'b1;
      @(negedge clk); drive_vec(0);
      @(negedge clk); drive_vec(1);
      @(negedge clk); drive_vec(2);
      @(negedge clk);
      chk("pre_rst_valid", a_out_valid, 1);
      chk("pre_rst_cnt", a_op_count, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", a_out_valid, 0);
      chk("arst_cnt", a_op_count, 0);
      chk("arst_cnt_b", b_op_count, 0);
      chk("arst_y", a_out_y, 0);
      chk("arst_flags", {a_out_zero, a_out_ones, a_out_parity}, 0);
      iv = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cnt_a = 0; cnt_b = 0;
      vecs[0] = '{OP_AND, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
      stream(1);

      // WIDTH=1 flag identities
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            k = t - 2;
            yd = ref_y(3'(k), 16'(k & 1), 16'((k >> 1) & 1), 1);
            chk("w1_valid", d_out_valid, 1);
            chk("w1_y", d_out_y, yd[0]);
            chk("w1_flags", {d_out_zero, d_out_ones, d_out_parity}, {~yd[0], yd[0], yd[0]});
         end
         if (t < 8) begin
            d_in_valid = 1'b1; d_in_op = 3'(t); d_in_a = 1'(t & 1); d_in_b = 1'((t >> 1) & 1);
         end else begin
            d_in_valid = 1'b0;
         end
      end

      // WIDTH=16 random traffic against a scoreboard
      sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
      while ((sent < 1000 || sb.size() > 0) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (stall)
            chk("c_hold", {c_out_valid, c_out_y, c_out_zero, c_out_ones, c_out_parity}, {1'b1, held});
         c_in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
         c_in_a      = 16'($urandom);
         c_in_b      = 16'($urandom);
         c_in_op     = 3'($urandom_range(7));
         c_out_ready = (sent >= 1000) || ($urandom_range(2) != 0);
         #1;
         if (c_in_valid && c_in_ready) begin
            yc = ref_y(c_in_op, c_in_a, c_in_b, 16);
            sb.push_back({yc, ref_flags(yc, 16)});
            sent++;
         end
         if (c_out_valid && c_out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL c_unexpected actual=%0h required=none", c_out_y);
            end else begin
               exp_c = sb.pop_front();
               chk("c_result", {c_out_y, c_out_zero, c_out_ones, c_out_parity}, exp_c);
               got++;
            end
         end
         stall = c_out_valid && !c_out_ready;
         held  = {c_out_y, c_out_zero, c_out_ones, c_out_parity};
      end
      c_in_valid = 1'b0;
      chk("c_delivered", got, 1000);
      chk("c_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
